rvga_mem_arbiter: RTL and testbench
===================================

# rvga_mem_arbiter

Two-port arbiter sharing the single DDR word port between the instruction-fetch port (read-only) and the data port (read/write). It serialises requests, captures address and write data on grant, drives the DDR read/write levels until `ddr_resp`, and returns registered read data with a one-cycle response pulse. Round-robin fairness applies on contention, and a watchdog terminates hung transactions with an error pulse. It sits between the core's fetch/memory stages and the DDR model/controller.

## Interface
- `TIMEOUT`, 64: cycles in a grant state without `ddr_resp` before abort; must be ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_addr` in 32: fetch address (`rvga_word`).
- `i_read` in 1: fetch request level.
- `i_rdata` out 32: fetch read data.
- `i_resp` out 1: fetch response pulse.
- `d_addr` in 32: data address.
- `d_read` in 1: data read request level.
- `d_write` in 1: data write request level; `d_read` and `d_write` are never both high.
- `d_wdata` in 32: data write word.
- `d_rdata` out 32: data read data.
- `d_resp` out 1: data response pulse.
- `d_err` out 1: data or fetch timeout pulse; it is coincident with the failing port's `*_resp`.
- `ddr_addr` out 32, `ddr_read` out 1, `ddr_write` out 1, `ddr_wdata` out 32: DDR command.
- `ddr_rdata` in 32, `ddr_resp` in 1: DDR return; `ddr_resp` is a one-cycle pulse.

## Operation
- States: IDLE, GNT_I, GNT_D, RESP.
- **IDLE**
  - Only `i_read` high: capture `i_addr` into `addr_q`, go to GNT_I.
  - Only `d_read|d_write` high: capture `d_addr`, `d_wdata`, and the write flag, go to GNT_D.
  - Both high: grant the port not recorded in `last_q`.
  - On every grant, set `last_q` to the granted port.
  - Reset value of `last_q` = data, so fetch wins the first contention.
- **GNT_I / GNT_D**
  - `ddr_addr` = `addr_q & ~32'h3`.
  - `ddr_read` = 1 in GNT_I, or in GNT_D for a read.
  - `ddr_write` = 1 in GNT_D for a write.
  - `ddr_wdata` = `wdata_q`.
  - Command outputs are decoded from registered state and flags only, with no combinational path from requester inputs.
  - The watchdog counter clears on grant and increments each cycle in a grant state.
  - `ddr_resp`=1 sampled: latch `ddr_rdata` into the granted port's rdata register (writes leave it unchanged), go to RESP.
  - Counter reaches `TIMEOUT-1` without `ddr_resp`: go to RESP with error flag set; rdata register is loaded with 32'h0.
- **RESP**
  - `ddr_read`=`ddr_write`=0, giving the DDR side one idle cycle to return to its idle state.
  - Granted port's `*_resp`=1; `d_err`=error flag.
  - Next edge: go to IDLE and clear the error flag.
- **Requester rule:** hold address, data, and request stable until `*_resp`. Drop the request at the same edge that samples `*_resp`=1, so IDLE sees only new requests.
- `ddr_resp` outside GNT_I/GNT_D is ignored.
- Requests withdrawn mid-grant are not cancelled: the captured transaction completes and still pulses `*_resp`.

## Timing
- **Reset (async):**
  - state=IDLE, `last_q`=data, counter=0.
  - `i_resp`=`d_resp`=`d_err`=0.
  - `ddr_read`=`ddr_write`=0.
  - `ddr_addr`=`ddr_wdata`=0.
  - `i_rdata`=`d_rdata`=0.
- Reset mid-grant drops the DDR command immediately; no response is issued for the aborted transaction.
- **Latency:**
  - Request sampled at edge E0 → command high from E0 to the edge sampling `ddr_resp`.
  - `*_resp` high exactly one cycle, the cycle after `ddr_resp` is sampled.
  - For DDR latency L cycles (command-seen to `ddr_resp`), request-to-`*_resp` = L+2 cycles.
- **Throughput:** minimum 3 cycles per transaction (grant, resp, idle). Back-to-back transactions from alternating ports alternate strictly.
- `*_rdata` holds its value until the next response to that port.

## Test plan
- **Single fetch:** `i_read`=1, `i_addr`=0x10, DDR returns 0x00000013 after 2 cycles → one `i_resp` pulse, `i_rdata`=0x00000013, `d_resp`=0, `ddr_addr`=0x10.
- **Write then read:** data write 0xCAFEF00D to 0x23, then read 0x20 → `ddr_addr`=0x20 for both transactions, `d_rdata`=0xCAFEF00D, `ddr_write` high only during the write grant.
- **Contention:** `i_read` and `d_read` held high from reset through 4 transactions → grants I, D, I, D. Each port receives exactly one `*_resp` per transaction; DDR command is low for at least one cycle between transactions.
- **Timeout:** `TIMEOUT`=8, DDR never responds to a `d_read` → `d_resp`=`d_err`=1 on cycle 9 after grant, `d_rdata`=0, next `i_read` is served normally.
- **Reset mid-grant:** `rst` asserted during GNT_D → `ddr_read`/`ddr_write` drop asynchronously and no `d_resp` appears. After release, a stray `ddr_resp` pulse is ignored and the first contention grants fetch.
- **Spurious response:** `ddr_resp` pulsed while IDLE → no `*_resp`, and rdata registers are unchanged.

Source files
------------

// File: rtl/rvga_mem_arbiter.sv
// Shares one DDR word port between the fetch port and the data port.
// Round-robin on contention; a watchdog ends hung transactions with d_err.
module rvga_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        d_err,
    output logic [31:0] ddr_addr,
    output logic        ddr_read,
    output logic        ddr_write,
    output logic [31:0] ddr_wdata,
    input  logic [31:0] ddr_rdata,
    input  logic        ddr_resp
);
    // state | meaning
    // IDLE  | no transaction; arbitration between pending requests
    // GNT_I | fetch transaction driving the DDR port
    // GNT_D | data transaction driving the DDR port
    // RESP  | response pulse to the granted port; DDR command idle
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            last_q, last_d;     // 1: data port was granted last
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic d_req, grant_i, in_gnt;

    assign d_req   = d_read | d_write;
    assign grant_i = i_read & (~d_req | last_q);
    assign in_gnt  = (state_q == GNT_I) || (state_q == GNT_D);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wr_d      = wr_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = GNT_I;
                    last_d  = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = 32'h0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end else if (d_req) begin
                    state_d = GNT_D;
                    last_d  = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wr_d    = d_write;
                    cnt_d   = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (ddr_resp) begin
                    state_d = RESP;
                    if (state_q == GNT_I) begin
                        i_rdata_d = ddr_rdata;
                    end else if (!wr_q) begin
                        d_rdata_d = ddr_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Hung transaction: report through the granted port with zero data.
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (state_q == GNT_I) begin
                        i_rdata_d = 32'h0;
                    end else begin
                        d_rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            cnt_q     <= '0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // DDR command comes only from registered state so requesters cannot glitch it.
    assign ddr_read  = (state_q == GNT_I) || ((state_q == GNT_D) && !wr_q);
    assign ddr_write = (state_q == GNT_D) && wr_q;
    assign ddr_addr  = in_gnt ? (addr_q & ~32'h3) : 32'h0;
    assign ddr_wdata = in_gnt ? wdata_q : 32'h0;

    assign i_resp  = (state_q == RESP) && !last_q;
    assign d_resp  = (state_q == RESP) && last_q;
    assign d_err   = (state_q == RESP) && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Randomized bench for rvga_mem_arbiter: the bench plays both requesters and
// the DDR side, and predicts grants, timing and data from a transaction model.
module tb_rvga_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, d_wdata, ddr_rdata;
    logic        i_read, d_read, d_write, ddr_resp;
    logic [31:0] i_rdata, d_rdata, ddr_addr, ddr_wdata;
    logic        i_resp, d_resp, d_err, ddr_read, ddr_write;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [16];
    logic [31:0] exp_i_rdata, exp_d_rdata;
    bit          last_was_d, i_pend, d_pend;

    rvga_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_err(d_err),
        .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_write(ddr_write),
        .ddr_wdata(ddr_wdata), .ddr_rdata(ddr_rdata), .ddr_resp(ddr_resp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rdata();
        check_eq("i_rdata", i_rdata, exp_i_rdata);
        check_eq("d_rdata", d_rdata, exp_d_rdata);
    endtask

    task automatic new_requests();
        if (!i_pend && $urandom_range(0, 2) != 0) begin
            i_pend = 1'b1;
            i_read = 1'b1;
            i_addr = $urandom;
        end
        if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend  = 1'b1;
            d_addr  = $urandom;
            d_write = 1'($urandom_range(0, 1));
            d_read  = ~d_write;
            d_wdata = $urandom;
        end
    endtask

    // Entered in an IDLE cycle with the granted port's request already applied.
    task automatic run_txn(input bit g_d, input bit to, input int lat);
        logic [31:0] a, wd, rd;
        bit          wr, withdraw;
        a        = (g_d ? d_addr : i_addr) & ~32'h3;
        wr       = g_d && d_write;
        wd       = d_wdata;
        rd       = 32'h0;
        withdraw = ($urandom_range(0, 7) == 0);
        step();
        ddr_resp = 1'b0;
        for (int k = 0; k < TO; k++) begin
            check_eq("gnt_ddr_read", 32'(ddr_read), 32'(!wr));
            check_eq("gnt_ddr_write", 32'(ddr_write), 32'(wr));
            check_eq("gnt_ddr_addr", ddr_addr, a);
            if (wr) check_eq("gnt_ddr_wdata", ddr_wdata, wd);
            check_eq("gnt_no_resp", 32'({i_resp, d_resp}), 32'h0);
            check_rdata();
            if (withdraw && k == 0) begin
                if (g_d) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end else begin
                    i_read = 1'b0;
                end
            end
            if (!to && k == lat) begin
                ddr_resp = 1'b1;
                if (wr) ddr_rdata = $urandom;
                else    ddr_rdata = mem[a[5:2]];
                rd = ddr_rdata;
            end
            step();
            ddr_resp = 1'b0;
            if (!to && k == lat) break;
        end
        if (to) begin
            if (g_d) exp_d_rdata = 32'h0;
            else     exp_i_rdata = 32'h0;
        end else if (!g_d) begin
            exp_i_rdata = rd;
        end else if (!wr) begin
            exp_d_rdata = rd;
        end else begin
            mem[a[5:2]] = wd;
        end
        check_eq("resp_i", 32'(i_resp), 32'(!g_d));
        check_eq("resp_d", 32'(d_resp), 32'(g_d));
        check_eq("resp_err", 32'(d_err), 32'(to));
        check_eq("resp_cmd_idle", 32'({ddr_read, ddr_write}), 32'h0);
        check_rdata();
        if (g_d) begin
            d_pend  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_pend = 1'b0;
            i_read = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
            ddr_resp  = 1'b1;
            ddr_rdata = $urandom;
        end
        step();
        ddr_resp = 1'b0;
    endtask

    task automatic run_random(input int n);
        bit g_d, to;
        int lat;
        for (int t = 0; t < n; t++) begin
            new_requests();
            check_eq("idle_cmd", 32'({ddr_read, ddr_write}), 32'h0);
            check_eq("idle_resp", 32'({i_resp, d_resp, d_err}), 32'h0);
            check_rdata();
            if ($urandom_range(0, 4) == 0) begin
                ddr_resp  = 1'b1;
                ddr_rdata = $urandom;
            end
            if (!i_pend && !d_pend) begin
                step();
                ddr_resp = 1'b0;
                continue;
            end
            g_d        = (i_pend && d_pend) ? !last_was_d : d_pend;
            last_was_d = g_d;
            to         = (t == 3) || ($urandom_range(0, 9) == 0);
            lat        = $urandom_range(0, TO - 1);
            run_txn(g_d, to, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_addr = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        ddr_resp = 1'b0; ddr_rdata = 32'h0;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
        last_was_d = 1'b1; i_pend = 1'b0; d_pend = 1'b0;

        #12;
        check_eq("rst_cmd", 32'({ddr_read, ddr_write}), 32'h0);
        check_eq("rst_ddr_addr", ddr_addr, 32'h0);
        check_eq("rst_ddr_wdata", ddr_wdata, 32'h0);
        check_eq("rst_resp", 32'({i_resp, d_resp, d_err}), 32'h0);
        check_rdata();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single fetch from 0x10.
        mem[4] = 32'h0000_0013;
        i_pend = 1'b1; i_read = 1'b1; i_addr = 32'h10;
        last_was_d = 1'b0;
        run_txn(1'b0, 1'b0, 2);
        check_eq("fetch_rdata", i_rdata, 32'h0000_0013);

        // Write 0x23 then read 0x20.
        d_pend = 1'b1; d_write = 1'b1; d_read = 1'b0; d_addr = 32'h23; d_wdata = 32'hCAFE_F00D;
        last_was_d = 1'b1;
        run_txn(1'b1, 1'b0, 1);
        d_pend = 1'b1; d_write = 1'b0; d_read = 1'b1; d_addr = 32'h20;
        run_txn(1'b1, 1'b0, 0);
        check_eq("wr_rd_rdata", d_rdata, 32'hCAFE_F00D);

        run_random(120);

        // Reset in the middle of a data grant.
        i_read = 1'b0; i_pend = 1'b0;
        d_read = 1'b1; d_write = 1'b0; d_addr = $urandom; d_pend = 1'b1;
        step();
        check_eq("pre_rst_ddr_read", 32'(ddr_read), 32'h1);
        #2 rst = 1'b1;
        #1;
        d_read = 1'b0; d_pend = 1'b0;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0; last_was_d = 1'b1;
        check_eq("async_rst_cmd", 32'({ddr_read, ddr_write}), 32'h0);
        check_eq("async_rst_resp", 32'({i_resp, d_resp, d_err}), 32'h0);
        check_rdata();
        step();
        check_eq("rst_hold_resp", 32'({i_resp, d_resp}), 32'h0);
        rst = 1'b0;
        ddr_resp = 1'b1; ddr_rdata = $urandom;
        step();
        ddr_resp = 1'b0;
        check_eq("stray_resp", 32'({i_resp, d_resp, d_err}), 32'h0);
        check_eq("stray_cmd", 32'({ddr_read, ddr_write}), 32'h0);
        check_rdata();

        // Contention right after reset must go to fetch first.
        i_pend = 1'b1; i_read = 1'b1; i_addr = $urandom;
        d_pend = 1'b1; d_read = 1'b1; d_write = 1'b0; d_addr = $urandom; d_wdata = $urandom;
        run_random(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
